wave_sine_ctrl: RTL and testbench
=================================

WAVE_SINE_CTRL -- requirements
Module: wave_sine_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 10: sine phase index width, which equals log2 of the sine table depth of 1024.
REQ-003 SHALL have parameter CNT_W, default 16: burst counter width.
REQ-004 i_clk  input  1  single clock; all flops rise on the posedge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  one-cycle pulse that starts a burst.
REQ-007 i_stop  input  1  one-cycle pulse that aborts a run.
REQ-008 i_ftw  input  PHASE_W  frequency tuning word; output frequency = ftw * f_clk / 2^PHASE_W.
REQ-009 i_phase_ofs  input  ADDR_W  phase offset added to each index.
REQ-010 i_burst_len  input  CNT_W  number of samples per burst; 0 means continuous.
REQ-011 i_ready  input  1  downstream accepts the current sample.
REQ-012 o_phase_count  output  ADDR_W  phase index driven to the sine lookup.
REQ-013 o_valid  output  1  the sine lookup output is valid this cycle.
REQ-014 o_busy  output  1  high when the state is not IDLE.
REQ-015 o_done  output  1  one-cycle pulse when a burst completes.

Function
REQ-016 SHALL implement states IDLE, RUN and DRAIN.
REQ-017 In IDLE, i_start SHALL:
- latch i_ftw, i_phase_ofs and i_burst_len;
- clear the accumulator and the issue counter;
- enter RUN on the next cycle.
REQ-018 i_start outside IDLE SHALL be ignored; i_stop in IDLE or DRAIN SHALL be ignored.
REQ-019 Issue condition: state == RUN and not (o_valid and not i_ready).
REQ-020 On each issue, SHALL register o_phase_count = acc[PHASE_W-1 -: ADDR_W] + ofs, taken mod 2^ADDR_W (wrap, no saturation).
REQ-021 On each issue, SHALL update acc += ftw, mod 2^PHASE_W, and increment the issue counter.
REQ-022 When not issuing, o_phase_count SHALL hold its value, so that the sine lookup output stays stable during a stall.
REQ-023 SHALL account for a fixed lookup latency of 1 cycle:
- o_valid is set the cycle after an issue;
- o_valid clears after it is accepted (o_valid and i_ready) with no new issue in the same cycle.
REQ-024 If issue and accept occur in the same cycle, o_valid SHALL remain 1 and the sample stream SHALL continue without a bubble.
REQ-025 RUN -> DRAIN SHALL occur when burst_len != 0 and the issue that brings the counter to burst_len happens, or when i_stop is high.
REQ-026 If i_stop coincides with an issue, that issue SHALL complete; no further issue follows.
REQ-027 DRAIN -> IDLE SHALL occur when no sample is outstanding (o_valid == 0, or the last sample is accepted this cycle).
REQ-028 o_done SHALL pulse for exactly 1 cycle on the DRAIN -> IDLE transition, for both the burst-complete and stop cases.
REQ-029 With burst_len = 0, the issue counter SHALL wrap freely and never end the burst.
REQ-030 ftw = 0 SHALL produce a constant index, equal to ofs.

Reset
REQ-031 Asserting i_rst at any time, including mid-burst, SHALL immediately force:
- state IDLE;
- acc, counter and latched configuration to 0;
- o_phase_count = 0, o_valid = 0, o_busy = 0, o_done = 0.
REQ-032 No sample, and no o_done pulse, SHALL be emitted for a burst interrupted by reset.

Structure
REQ-033 Package wave_pkg SHALL hold:
- the state enum typedef;
- default constants PHASE_W, ADDR_W, CNT_W;
- the lookup latency constant LUT_LAT = 1.
REQ-034 Sub-module phase_acc SHALL contain the accumulator register, with clear, enable, ftw input and an accumulator-value output.
REQ-035 The top level SHALL hold the FSM, issue counter, offset adder and valid tracking.

Verification
REQ-036 ftw = 2^22, ofs = 0, len = 4, i_ready = 1 -> indices 0, 1, 2, 3 on consecutive cycles; o_valid high for 4 cycles; o_done one cycle after the last valid.
REQ-037 ftw = 2^31, ofs = 1023, len = 3 -> indices 1023, 511, 1023 (offset wrap-around).
REQ-038 len = 5 with i_ready low for 3 cycles after the 2nd valid -> the 2nd index and o_valid hold for 3 cycles; the total accepted count is exactly 5.
REQ-039 len = 0, then i_stop after 10 issues -> exactly 10 valids; o_done pulses once; o_busy then falls.
REQ-040 i_rst asserted mid-RUN with o_valid = 1 -> all outputs 0 immediately; no o_done pulse; a new i_start afterwards restarts from index = ofs.
REQ-041 i_start during RUN with a different ftw -> ignored; the original sequence continues unchanged.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the sine-wave controller.
//   state_e  - controller FSM states
//   PHASE_W  - default phase accumulator width
//   ADDR_W   - default sine table index width (table depth 2^ADDR_W = 1024)
//   CNT_W    - default burst counter width
//   LUT_LAT  - cycles from index issue to valid sine sample
package wave_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LUT_LAT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/wave_sine_ctrl_if.sv
// Control / sample-stream bundle for wave_sine_ctrl.
//   i_start, i_stop          - one-cycle command pulses
//   i_ftw                    - frequency tuning word
//   i_phase_ofs              - phase offset added to every index
//   i_burst_len              - samples per burst, 0 = continuous
//   i_ready                  - downstream accepts the current sample
//   o_phase_count            - index driven to the sine lookup
//   o_valid, o_busy, o_done  - sample valid, not idle, burst finished pulse
// master: the side driving commands (bench / host); slave: the controller.
interface wave_sine_ctrl_if #(
    parameter int unsigned PHASE_W = wave_pkg::PHASE_W,
    parameter int unsigned ADDR_W  = wave_pkg::ADDR_W,
    parameter int unsigned CNT_W   = wave_pkg::CNT_W
) ();

    logic               i_start;
    logic               i_stop;
    logic [PHASE_W-1:0] i_ftw;
    logic [ADDR_W-1:0]  i_phase_ofs;
    logic [CNT_W-1:0]   i_burst_len;
    logic               i_ready;
    logic [ADDR_W-1:0]  o_phase_count;
    logic               o_valid;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_stop, i_ftw, i_phase_ofs, i_burst_len, i_ready,
        input  o_phase_count, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_ftw, i_phase_ofs, i_burst_len, i_ready,
        output o_phase_count, o_valid, o_busy, o_done
    );

endinterface

// File: rtl/phase_acc.sv
// Phase accumulator: acc <= 0 on clear, acc <= acc + ftw (wrapping) when enabled.
//   i_clk, i_rst - clock, async active-high reset
//   i_clr        - synchronous clear (wins over i_en)
//   i_en         - add i_ftw this cycle
//   i_ftw        - frequency tuning word
//   o_acc        - current accumulator value
module phase_acc #(
    parameter int unsigned PHASE_W = wave_pkg::PHASE_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_ftw,
    output logic [PHASE_W-1:0] o_acc
);

    logic [PHASE_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_q + i_ftw;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/wave_sine_ctrl.sv
// Burst controller for a DDS sine lookup. Issues one phase index per cycle while
// running and downstream is not stalled; a 1-cycle lookup follows each index, so
// o_valid is registered alongside o_phase_count.
//   i_clk, i_rst - clock, async active-high reset
//   bus (slave)  - commands, config, ready in; index / valid / busy / done out
module wave_sine_ctrl #(
    parameter int unsigned PHASE_W = wave_pkg::PHASE_W,
    parameter int unsigned ADDR_W  = wave_pkg::ADDR_W,
    parameter int unsigned CNT_W   = wave_pkg::CNT_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wave_sine_ctrl_if.slave bus
);

    import wave_pkg::*;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] ftw_q;
    logic [ADDR_W-1:0]  ofs_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0]  phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               start_ok, issue, last_issue, drained;
    logic [PHASE_W-1:0] acc;

    // Fractional phase bits only matter for the carry into the index bits.
    logic unused_acc_frac;
    assign unused_acc_frac = ^acc[PHASE_W-ADDR_W-1:0];

    phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (start_ok),
        .i_en  (issue),
        .i_ftw (ftw_q),
        .o_acc (acc)
    );

    always_comb begin
        start_ok   = (state_q == StIdle) && bus.i_start;
        // Stall only when a presented sample is being refused.
        issue      = (state_q == StRun) && !(valid_q && !bus.i_ready);
        cnt_inc    = cnt_q + 1'b1;
        last_issue = issue && (len_q != '0) && (cnt_inc == len_q);
        drained    = !valid_q || bus.i_ready;

        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (last_issue || bus.i_stop) state_d = StDrain;
            StDrain: begin
                if (drained) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        cnt_d = cnt_q;
        if (start_ok) begin
            cnt_d = '0;
        end else if (issue) begin
            cnt_d = cnt_inc;
        end

        // Index holds while stalled so the lookup output stays put.
        phase_d = issue ? (acc[PHASE_W-1 -: ADDR_W] + ofs_q) : phase_q;

        // Issue and accept in the same cycle keep valid high: no bubble.
        valid_d = valid_q;
        if (issue) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            ftw_q   <= '0;
            ofs_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (start_ok) begin
                ftw_q <= bus.i_ftw;
                ofs_q <= bus.i_phase_ofs;
                len_q <= bus.i_burst_len;
            end
        end
    end

    assign bus.o_phase_count = phase_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_busy        = (state_q != StIdle);
    assign bus.o_done        = done_q;

endmodule

// File: tb/tb_wave_sine_ctrl.sv
// Self-checking bench for wave_sine_ctrl. Expected indices come from the closed
// form idx[k] = ((k * ftw) mod 2^32)[31:22] + ofs (mod 1024).
module tb_wave_sine_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wave_sine_ctrl_if bus ();

    wave_sine_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [9:0] exp_idx(input logic [31:0] ftw, input logic [9:0] ofs,
                                           input int unsigned k);
        logic [31:0] a;
        a = ftw * 32'(k);
        return a[31:22] + ofs;
    endfunction

    task automatic start_burst(input logic [31:0] ftw, input logic [9:0] ofs,
                               input logic [15:0] len);
        @(negedge clk);
        bus.i_ftw       = ftw;
        bus.i_phase_ofs = ofs;
        bus.i_burst_len = len;
        bus.i_start     = 1'b1;
        @(negedge clk);
        bus.i_start     = 1'b0;
        // Scramble config inputs: the controller must use its latched copy.
        bus.i_ftw       = $urandom;
        bus.i_phase_ofs = 10'($urandom);
        bus.i_burst_len = 16'($urandom);
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_ftw = '0;
        bus.i_phase_ofs = '0;
        bus.i_burst_len = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_phase_count, bus.o_valid, bus.o_busy, bus.o_done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus.o_phase_count, bus.o_valid, bus.o_busy, bus.o_done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int first_v, last_v, done_at, nv, dn;
        bus.i_ready = 1'b1;
        start_burst(32'h0040_0000, 10'd0, 16'd4);
        first_v = -1; last_v = -1; done_at = -1; nv = 0; dn = 0;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                checks++;
                if (bus.o_phase_count !== 10'(nv)) begin
                    failures++;
                    $display("FAIL basic_idx got=%0d want=%0d", bus.o_phase_count, nv);
                end
                if (first_v < 0) first_v = s;
                last_v = s;
                nv++;
            end
            if (bus.o_done === 1'b1) begin
                if (done_at < 0) done_at = s;
                dn++;
            end
        end
        checks++;
        if (nv != 4) begin failures++; $display("FAIL basic_valid_count got=%0d want=4", nv); end
        checks++;
        if (first_v != 1 || last_v != 4) begin
            failures++;
            $display("FAIL basic_valid_window got=%0d..%0d want=1..4", first_v, last_v);
        end
        checks++;
        if (dn != 1 || done_at != last_v + 1) begin
            failures++;
            $display("FAIL basic_done got=%0d pulses at %0d want=1 at %0d", dn, done_at, last_v + 1);
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b want=0", bus.o_busy); end
    endtask

    task automatic test_random_bursts();
        logic [31:0] ftw;
        logic [9:0]  ofs, prev_idx;
        logic [15:0] len;
        int          acc_n, done_n;
        logic        rdy, prev_stall, fin;
        for (int it = 0; it < 12; it++) begin
            case (it)
                0:       begin ftw = 32'h8000_0000; ofs = 10'd1023; len = 16'd3; end
                1:       begin ftw = 32'd0; ofs = 10'($urandom); len = 16'd6; end
                2:       begin ftw = 32'hFFFF_FFFF; ofs = 10'($urandom); len = 16'd1; end
                default: begin ftw = $urandom; ofs = 10'($urandom);
                               len = 16'($urandom_range(1, 24)); end
            endcase
            start_burst(ftw, ofs, len);
            acc_n = 0; done_n = 0; prev_stall = 1'b0; fin = 1'b0; prev_idx = '0;
            for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
                @(negedge clk);
                if (prev_stall) begin
                    checks++;
                    if (bus.o_valid !== 1'b1 || bus.o_phase_count !== prev_idx) begin
                        failures++;
                        $display("FAIL rand_stall_hold it=%0d got v=%b idx=%0d want v=1 idx=%0d",
                                 it, bus.o_valid, bus.o_phase_count, prev_idx);
                    end
                end
                if (bus.o_done === 1'b1) begin
                    done_n++;
                    fin = 1'b1;
                    checks++;
                    if (bus.o_busy !== 1'b0 || acc_n != int'(len)) begin
                        failures++;
                        $display("FAIL rand_done it=%0d got busy=%b accepted=%0d want busy=0 accepted=%0d",
                                 it, bus.o_busy, acc_n, len);
                    end
                end
                rdy = ($urandom_range(0, 3) != 0);
                bus.i_ready = rdy;
                if (bus.o_valid === 1'b1 && rdy) begin
                    checks++;
                    if (bus.o_phase_count !== exp_idx(ftw, ofs, acc_n)) begin
                        failures++;
                        $display("FAIL rand_idx it=%0d k=%0d got=%0d want=%0d",
                                 it, acc_n, bus.o_phase_count, exp_idx(ftw, ofs, acc_n));
                    end
                    acc_n++;
                end
                prev_stall = (bus.o_valid === 1'b1) && !rdy;
                prev_idx = bus.o_phase_count;
            end
            checks++;
            if (!fin || acc_n != int'(len)) begin
                failures++;
                $display("FAIL rand_burst it=%0d got done=%b accepted=%0d want done=1 accepted=%0d",
                         it, fin, acc_n, len);
            end
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_stall();
        logic [31:0] ftw;
        logic [9:0]  ofs, prev_idx;
        int          seen, acc_n, low_left, holds, done_n;
        logic        rdy, prev_stall, fin;
        ftw = $urandom; ofs = 10'($urandom);
        bus.i_ready = 1'b1;
        start_burst(ftw, ofs, 16'd5);
        seen = 0; acc_n = 0; low_left = 0; holds = 0; done_n = 0;
        prev_stall = 1'b0; fin = 1'b0; prev_idx = '0;
        for (int s = 0; s < 40 && !fin; s++) begin
            @(negedge clk);
            if (prev_stall) begin
                holds++;
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_phase_count !== prev_idx) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b idx=%0d want v=1 idx=%0d",
                             bus.o_valid, bus.o_phase_count, prev_idx);
                end
            end else if (bus.o_valid === 1'b1) begin
                seen++;
                if (seen == 2) low_left = 3;
            end
            if (bus.o_done === 1'b1) begin done_n++; fin = 1'b1; end
            rdy = (low_left == 0);
            if (low_left > 0) low_left--;
            bus.i_ready = rdy;
            if (bus.o_valid === 1'b1 && rdy) begin
                checks++;
                if (bus.o_phase_count !== exp_idx(ftw, ofs, acc_n)) begin
                    failures++;
                    $display("FAIL stall_idx k=%0d got=%0d want=%0d",
                             acc_n, bus.o_phase_count, exp_idx(ftw, ofs, acc_n));
                end
                acc_n++;
            end
            prev_stall = (bus.o_valid === 1'b1) && !rdy;
            prev_idx = bus.o_phase_count;
        end
        checks++;
        if (holds != 3) begin failures++; $display("FAIL stall_hold_cycles got=%0d want=3", holds); end
        checks++;
        if (acc_n != 5 || done_n != 1) begin
            failures++;
            $display("FAIL stall_total got accepted=%0d done=%0d want accepted=5 done=1", acc_n, done_n);
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_stop();
        logic [31:0] ftw;
        logic [9:0]  ofs;
        int          nv, done_n;
        ftw = $urandom; ofs = 10'($urandom);
        bus.i_ready = 1'b1;
        start_burst(ftw, ofs, 16'd0);
        nv = 0; done_n = 0;
        for (int s = 0; s < 25; s++) begin
            @(negedge clk);
            bus.i_stop = 1'b0;
            if (bus.o_done === 1'b1) done_n++;
            if (bus.o_valid === 1'b1) begin
                checks++;
                if (bus.o_phase_count !== exp_idx(ftw, ofs, nv)) begin
                    failures++;
                    $display("FAIL stop_idx k=%0d got=%0d want=%0d",
                             nv, bus.o_phase_count, exp_idx(ftw, ofs, nv));
                end
                nv++;
                if (nv == 9) bus.i_stop = 1'b1;
            end
        end
        checks++;
        if (nv != 10) begin failures++; $display("FAIL stop_valid_count got=%0d want=10", nv); end
        checks++;
        if (done_n != 1) begin failures++; $display("FAIL stop_done_count got=%0d want=1", done_n); end
        checks++;
        if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b want=0", bus.o_busy); end
        // Stop while idle does nothing.
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got busy=%b done=%b valid=%b want 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_valid);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] ftw;
        logic [9:0]  ofs;
        int          acc_n, done_n;
        logic        rdy, fin, pulsed;
        ftw = $urandom; ofs = 10'($urandom);
        start_burst(ftw, ofs, 16'd8);
        acc_n = 0; done_n = 0; fin = 1'b0; pulsed = 1'b0;
        for (int s = 0; s < 100 && !fin; s++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_done === 1'b1) begin done_n++; fin = 1'b1; end
            rdy = ($urandom_range(0, 2) != 0);
            bus.i_ready = rdy;
            if (bus.o_valid === 1'b1 && rdy) begin
                checks++;
                if (bus.o_phase_count !== exp_idx(ftw, ofs, acc_n)) begin
                    failures++;
                    $display("FAIL restart_idx k=%0d got=%0d want=%0d",
                             acc_n, bus.o_phase_count, exp_idx(ftw, ofs, acc_n));
                end
                acc_n++;
                if (acc_n == 3 && !pulsed) begin
                    pulsed = 1'b1;
                    bus.i_start     = 1'b1;
                    bus.i_ftw       = (ftw ^ 32'h1234_5678) | 32'h0040_0000;
                    bus.i_phase_ofs = ofs + 10'd5;
                    bus.i_burst_len = 16'd2;
                end
            end
        end
        bus.i_start = 1'b0;
        checks++;
        if (acc_n != 8 || done_n != 1) begin
            failures++;
            $display("FAIL restart_total got accepted=%0d done=%0d want accepted=8 done=1",
                     acc_n, done_n);
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] ftw;
        logic [9:0]  ofs;
        int          nv, bad;
        logic        seen, fin;
        ftw = $urandom; ofs = 10'($urandom);
        bus.i_ready = 1'b1;
        start_burst(ftw, ofs, 16'd0);
        nv = 0;
        for (int s = 0; s < 20 && nv < 5; s++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 5 || bus.o_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_run got valids=%0d valid=%b want 5 1", nv, bus.o_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_phase_count, bus.o_valid, bus.o_busy, bus.o_done} !== 13'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h want=0",
                     {bus.o_phase_count, bus.o_valid, bus.o_busy, bus.o_done});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_quiet got=%0d active cycles want=0", bad); end
        ofs = 10'($urandom);
        start_burst(ftw, ofs, 16'd3);
        seen = 1'b0;
        for (int s = 0; s < 5 && !seen; s++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (bus.o_phase_count !== ofs) begin
                    failures++;
                    $display("FAIL rst_restart_idx got=%0d want=%0d", bus.o_phase_count, ofs);
                end
            end
        end
        fin = 1'b0;
        for (int s = 0; s < 20 && !fin; s++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) fin = 1'b1;
        end
        checks++;
        if (!seen || !fin) begin
            failures++;
            $display("FAIL rst_restart_burst got valid=%b done=%b want 1 1", seen, fin);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_bursts();
        test_stall();
        test_stop();
        test_start_ignored();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
